// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: two requester ports (control unit and
// program loader/debug) plus the single-port memory strobe/data signals.
// The slave modport is the arbiter's view; master is the requesters/memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              cu_req;
    logic              cu_we;
    logic [ADDR_W-1:0] cu_addr;
    logic [DATA_W-1:0] cu_wdata;
    logic              cu_gnt;
    logic              cu_done;
    logic [DATA_W-1:0] cu_rdata;

    logic              ldr_req;
    logic              ldr_we;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic              ldr_gnt;
    logic              ldr_done;
    logic [DATA_W-1:0] ldr_rdata;

    logic              Mem_CS;
    logic              Mem_WR;
    logic [ADDR_W-1:0] Mem_Address;
    logic [DATA_W-1:0] Mem_Data;
    logic [DATA_W-1:0] Mem_Q;

    modport slave (
        input  cu_req, cu_we, cu_addr, cu_wdata,
        output cu_gnt, cu_done, cu_rdata,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output ldr_gnt, ldr_done, ldr_rdata,
        output Mem_CS, Mem_WR, Mem_Address, Mem_Data,
        input  Mem_Q
    );

    modport master (
        output cu_req, cu_we, cu_addr, cu_wdata,
        input  cu_gnt, cu_done, cu_rdata,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  ldr_gnt, ldr_done, ldr_rdata,
        input  Mem_CS, Mem_WR, Mem_Address, Mem_Data,
        output Mem_Q
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the control unit
// (cu) and the program loader/debug port (ldr). Each beat is two cycles:
// ACC (memory strobed, read data captured at its end) then RESP (done pulse).
// An owner may chain beats, but while the other side waits it is limited to
// MAX_BURST beats before the port is forcibly handed over.
// Optional feature: define MEM_ARB_RR_EN for round-robin tie breaking in
// IDLE; without it, ties go to the control unit.
module mem_port_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    mem_port_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic       OWN_CU  = 1'b0;
    localparam logic       OWN_LDR = 1'b1;
    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

    state_t            state;
    logic              owner;
    logic              last_owner;
    logic              force_other;
    logic [3:0]        burst_cnt;

    logic              own_req;
    logic              other_req;
    logic              own_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              pick;

    // Route the current owner's request signals and the waiting side's request.
    always_comb begin
        own_req   = bus.cu_req;
        other_req = bus.ldr_req;
        own_we    = bus.cu_we;
        sel_addr  = bus.cu_addr;
        sel_wdata = bus.cu_wdata;
        if (owner == OWN_LDR) begin
            own_req   = bus.ldr_req;
            other_req = bus.cu_req;
            own_we    = bus.ldr_we;
            sel_addr  = bus.ldr_addr;
            sel_wdata = bus.ldr_wdata;
        end
    end

    // Choose the winner in IDLE; a forced hand-over beats the normal tie rule.
    always_comb begin
        pick = OWN_CU;
        if (bus.cu_req && bus.ldr_req) begin
            if (force_other) begin
                pick = ~owner;
            end else begin
`ifdef MEM_ARB_RR_EN
                pick = ~last_owner;
`else
                pick = OWN_CU;
`endif
            end
        end else if (bus.ldr_req) begin
            pick = OWN_LDR;
        end
    end

    // Memory strobe is decoded from the state so reset releases it at once.
    assign bus.Mem_CS      = (state != S_ACC);
    assign bus.Mem_WR      = (state == S_ACC) && own_we;
    assign bus.Mem_Address = (state == S_ACC) ? sel_addr  : '0;
    assign bus.Mem_Data    = (state == S_ACC) ? sel_wdata : '0;

    // Arbitration FSM with registered grants, done pulses and read data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            owner         <= OWN_LDR;
            last_owner    <= OWN_LDR;
            force_other   <= 1'b0;
            burst_cnt     <= 4'd0;
            bus.cu_gnt    <= 1'b0;
            bus.ldr_gnt   <= 1'b0;
            bus.cu_done   <= 1'b0;
            bus.ldr_done  <= 1'b0;
            bus.cu_rdata  <= '0;
            bus.ldr_rdata <= '0;
        end else begin
            bus.cu_done  <= 1'b0;
            bus.ldr_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.cu_req || bus.ldr_req) begin
                        state       <= S_ACC;
                        owner       <= pick;
                        last_owner  <= pick;
                        force_other <= 1'b0;
                        bus.cu_gnt  <= (pick == OWN_CU);
                        bus.ldr_gnt <= (pick == OWN_LDR);
                        if (pick != owner) begin
                            burst_cnt <= 4'd0;
                        end
                    end
                end
                S_ACC: begin
                    state <= S_RESP;
                    if (owner == OWN_CU) begin
                        bus.cu_done <= 1'b1;
                        if (!bus.cu_we) begin
                            bus.cu_rdata <= bus.Mem_Q;
                        end
                    end else begin
                        bus.ldr_done <= 1'b1;
                        if (!bus.ldr_we) begin
                            bus.ldr_rdata <= bus.Mem_Q;
                        end
                    end
                    if (other_req && (burst_cnt != MAX_CNT)) begin
                        burst_cnt <= burst_cnt + 4'd1;
                    end
                end
                S_RESP: begin
                    if (own_req && other_req && (burst_cnt == MAX_CNT)) begin
                        state       <= S_IDLE;
                        force_other <= 1'b1;
                        bus.cu_gnt  <= 1'b0;
                        bus.ldr_gnt <= 1'b0;
                    end else if (own_req) begin
                        state <= S_ACC;
                    end else begin
                        state       <= S_IDLE;
                        bus.cu_gnt  <= 1'b0;
                        bus.ldr_gnt <= 1'b0;
                        burst_cnt   <= 4'd0;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    bus.cu_gnt  <= 1'b0;
                    bus.ldr_gnt <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: scenarios push the expected memory
// strobes and done responses in order; a negedge monitor pops and compares
// whenever the DUT strobes memory or pulses a done.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic       who;
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
    } strobe_t;

    typedef struct packed {
        logic       who;
        logic [7:0] rdata;
    } done_t;

    logic clock;
    logic reset;

    mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    mem_port_arbiter #(
        .ADDR_W   (8),
        .DATA_W   (8),
        .MAX_BURST(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    logic [7:0] tb_mem [256];
    logic [7:0] exp_rdata [2];
    strobe_t    strobe_q [$];
    done_t      done_q [$];
    strobe_t    se;
    done_t      de;
    int         checks   = 0;
    int         failures = 0;

    assign bus.Mem_Q = tb_mem[bus.Mem_Address];

    // Free-running clock, 10 time units per cycle.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural memory: written on the rising edge of a write strobe.
    always @(posedge clock) begin
        if (!bus.Mem_CS && bus.Mem_WR) begin
            tb_mem[bus.Mem_Address] <= bus.Mem_Data;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic void push_beat(input logic who, input logic we, input logic [7:0] addr,
                                      input logic [7:0] data, input logic [7:0] rval);
        strobe_t s;
        done_t   d;
        if (!we) begin
            exp_rdata[who] = rval;
        end
        s = '{who: who, we: we, addr: addr, data: data};
        d = '{who: who, rdata: exp_rdata[who]};
        strobe_q.push_back(s);
        done_q.push_back(d);
    endfunction

    task automatic drive(input logic who, input logic req, input logic we,
                         input logic [7:0] addr, input logic [7:0] wdata);
        if (who) begin
            bus.ldr_req = req; bus.ldr_we = we; bus.ldr_addr = addr; bus.ldr_wdata = wdata;
        end else begin
            bus.cu_req = req; bus.cu_we = we; bus.cu_addr = addr; bus.cu_wdata = wdata;
        end
    endtask

    // One requester: holds req for nbeats, stepping addr/wdata during each RESP.
    task automatic apply_stimulus(input logic who, input logic we, input logic [7:0] addr0,
                                  input logic [7:0] wdata0, input int nbeats);
        drive(who, 1'b1, we, addr0, wdata0);
        for (int i = 0; i < nbeats; i++) begin
            int waited = 0;
            bit seen   = 0;
            while (!seen && waited < 60) begin
                @(negedge clock);
                waited++;
                seen = who ? bus.ldr_done : bus.cu_done;
            end
            check_output(who ? "ldr_done_wait" : "cu_done_wait", 32'(seen), 32'd1);
            if (i == nbeats - 1) begin
                drive(who, 1'b0, 1'b0, 8'h00, 8'h00);
            end else begin
                drive(who, 1'b1, we, addr0 + 8'(i + 1), wdata0 + 8'(i + 1));
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((strobe_q.size() != 0 || done_q.size() != 0) && n < 200) begin
            @(negedge clock);
            n++;
        end
        check_output(name, 32'(strobe_q.size() + done_q.size()), 32'd0);
        strobe_q.delete();
        done_q.delete();
        repeat (2) @(negedge clock);
    endtask

    // Monitor: every strobe and done pulse must match the next expected entry.
    always @(negedge clock) begin
        if (!reset) begin
            if (!bus.Mem_CS) begin
                if (strobe_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_strobe actual addr=%0h required none", bus.Mem_Address);
                end else begin
                    se = strobe_q.pop_front();
                    check_output("strobe_gnt", {30'd0, bus.cu_gnt, bus.ldr_gnt}, se.who ? 32'd1 : 32'd2);
                    check_output("strobe_we", 32'(bus.Mem_WR), 32'(se.we));
                    check_output("strobe_addr", 32'(bus.Mem_Address), 32'(se.addr));
                    check_output("strobe_data", 32'(bus.Mem_Data), 32'(se.data));
                end
            end
            if (bus.cu_done || bus.ldr_done) begin
                if (done_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_done actual cu=%0b ldr=%0b required none", bus.cu_done, bus.ldr_done);
                end else begin
                    de = done_q.pop_front();
                    check_output("done_owner", {30'd0, bus.cu_done, bus.ldr_done}, de.who ? 32'd1 : 32'd2);
                    check_output("done_rdata", de.who ? 32'(bus.ldr_rdata) : 32'(bus.cu_rdata), 32'(de.rdata));
                end
            end
        end
    end

    // Watchdog so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios.
    initial begin
        for (int i = 0; i < 256; i++) tb_mem[i] = 8'h00;
        tb_mem[8'h10] = 8'h5A;
        tb_mem[8'h60] = 8'h3C;
        tb_mem[8'h61] = 8'h4D;
        for (int i = 0; i < 6; i++) tb_mem[8'h30 + i] = 8'hA0 + 8'(i);
        exp_rdata[0] = 8'h00;
        exp_rdata[1] = 8'h00;

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        check_output("rst_cs", 32'(bus.Mem_CS), 32'd1);
        check_output("rst_wr", 32'(bus.Mem_WR), 32'd0);
        check_output("rst_addr", 32'(bus.Mem_Address), 32'd0);
        check_output("rst_data", 32'(bus.Mem_Data), 32'd0);
        check_output("rst_gnt", {30'd0, bus.cu_gnt, bus.ldr_gnt}, 32'd0);
        check_output("rst_done", {30'd0, bus.cu_done, bus.ldr_done}, 32'd0);
        check_output("rst_rdata", {16'd0, bus.cu_rdata, bus.ldr_rdata}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check_output("idle_cs", 32'(bus.Mem_CS), 32'd1);

        // Tie straight after reset: cu first, then ldr.
        push_beat(1'b0, 1'b0, 8'h60, 8'h00, 8'h3C);
        push_beat(1'b1, 1'b0, 8'h61, 8'h00, 8'h4D);
        fork
            apply_stimulus(1'b0, 1'b0, 8'h60, 8'h00, 1);
            apply_stimulus(1'b1, 1'b0, 8'h61, 8'h00, 1);
        join
        wait_drain("tie1_drain");

        // Single cu read.
        push_beat(1'b0, 1'b0, 8'h10, 8'h00, 8'h5A);
        apply_stimulus(1'b0, 1'b0, 8'h10, 8'h00, 1);
        wait_drain("read_drain");

        // Single ldr write; ldr_rdata holds its last read value.
        push_beat(1'b1, 1'b1, 8'h20, 8'hC3, 8'h00);
        apply_stimulus(1'b1, 1'b1, 8'h20, 8'hC3, 1);
        wait_drain("write_drain");

        // Read the written location back through cu.
        push_beat(1'b0, 1'b0, 8'h20, 8'h00, 8'hC3);
        apply_stimulus(1'b0, 1'b0, 8'h20, 8'h00, 1);
        wait_drain("readback_drain");

        // Second tie, last grant went to cu.
`ifdef MEM_ARB_RR_EN
        push_beat(1'b1, 1'b0, 8'h30, 8'h00, 8'hA0);
        push_beat(1'b0, 1'b0, 8'h10, 8'h00, 8'h5A);
`else
        push_beat(1'b0, 1'b0, 8'h10, 8'h00, 8'h5A);
        push_beat(1'b1, 1'b0, 8'h30, 8'h00, 8'hA0);
`endif
        fork
            apply_stimulus(1'b0, 1'b0, 8'h10, 8'h00, 1);
            apply_stimulus(1'b1, 1'b0, 8'h30, 8'h00, 1);
        join
        wait_drain("tie2_drain");

        // Starvation limit: four cu beats, forced ldr beat, then cu resumes.
        for (int i = 0; i < 4; i++) push_beat(1'b0, 1'b0, 8'h30 + 8'(i), 8'(i), 8'hA0 + 8'(i));
        push_beat(1'b1, 1'b1, 8'h40, 8'h77, 8'h00);
        push_beat(1'b0, 1'b0, 8'h34, 8'h04, 8'hA4);
        push_beat(1'b0, 1'b0, 8'h35, 8'h05, 8'hA5);
        fork
            apply_stimulus(1'b0, 1'b0, 8'h30, 8'h00, 6);
            begin
                @(negedge clock);
                apply_stimulus(1'b1, 1'b1, 8'h40, 8'h77, 1);
            end
        join
        wait_drain("burst_drain");
        check_output("burst_memwrite", 32'(tb_mem[8'h40]), 32'h77);

        // Reset during ACC of a cu write: strobe drops at once, no done, no replay.
        drive(1'b0, 1'b1, 1'b1, 8'h50, 8'h99);
        @(posedge clock);
        #2;
        check_output("midbeat_cs_before", 32'(bus.Mem_CS), 32'd0);
        reset = 1'b1;
        #1;
        check_output("midbeat_cs", 32'(bus.Mem_CS), 32'd1);
        check_output("midbeat_wr", 32'(bus.Mem_WR), 32'd0);
        check_output("midbeat_addr", 32'(bus.Mem_Address), 32'd0);
        check_output("midbeat_gnt", {30'd0, bus.cu_gnt, bus.ldr_gnt}, 32'd0);
        check_output("midbeat_rdata", {16'd0, bus.cu_rdata, bus.ldr_rdata}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clock);
        check_output("midbeat_done", {30'd0, bus.cu_done, bus.ldr_done}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        check_output("post_reset_cs", 32'(bus.Mem_CS), 32'd1);
        check_output("post_reset_gnt", {30'd0, bus.cu_gnt, bus.ldr_gnt}, 32'd0);
        check_output("post_reset_mem", 32'(tb_mem[8'h50]), 32'd0);
        check_output("post_reset_queues", 32'(strobe_q.size() + done_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum chained beats while the other requester waits (range 1-15).
REQ-004 SHALL have port clock, in, 1, single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, in, 1, asynchronous, active-high reset.
REQ-006 SHALL have port cu_req, in, 1, control-unit access request; held until cu_done.
REQ-007 SHALL have port cu_we, in, 1, 1 = write, 0 = read.
REQ-008 SHALL have port cu_addr, in, ADDR_W, control-unit address.
REQ-009 SHALL have port cu_wdata, in, DATA_W, control-unit write data.
REQ-010 SHALL have port cu_gnt, out, 1, high while the control unit owns the port.
REQ-011 SHALL have port cu_done, out, 1, one-cycle beat-complete pulse.
REQ-012 SHALL have port cu_rdata, out, DATA_W, registered read data, valid while cu_done is high.
REQ-013 SHALL have ports ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_gnt, ldr_done and ldr_rdata, identical to the cu_* ports, serving the program loader/debug requester.
REQ-014 SHALL have port Mem_CS, out, 1, memory chip select, active-low.
REQ-015 SHALL have port Mem_WR, out, 1, memory write strobe, 1 = write.
REQ-016 SHALL have port Mem_Address, out, ADDR_W, address from the granted requester.
REQ-017 SHALL have port Mem_Data, out, DATA_W, write data from the granted requester.
REQ-018 SHALL have port Mem_Q, in, DATA_W, combinational memory read data.

Function
REQ-019 SHALL implement the states IDLE, ACC (memory strobed) and RESP (done pulse, memory idle); one beat costs exactly 2 cycles (ACC, then RESP).
REQ-020 SHALL, in IDLE with at least one req high, select an owner, assert its gnt and enter ACC on the next edge; with no req, it SHALL stay in IDLE.
REQ-021 SHALL, in ACC, drive Mem_CS=0, Mem_WR=owner we, and Mem_Address/Mem_Data from the owner; in every other state, Mem_CS=1, Mem_WR=0, and Mem_Address/Mem_Data=0.
REQ-022 SHALL, at the edge leaving ACC, register Mem_Q into the owner's rdata (read beats only; rdata holds its value otherwise) and pulse the owner's done for the whole RESP cycle.
REQ-023 SHALL, in RESP with the owner's req still high (new beat), go RESP->ACC with the same owner unless the other req is high and burst_cnt == MAX_BURST; in that case it SHALL go to IDLE and the other requester SHALL win the next arbitration unconditionally.
REQ-024 SHALL, in RESP with the owner's req low, go to IDLE, drop gnt and clear burst_cnt.
REQ-025 SHALL count consecutive beats of the same owner in burst_cnt (4 bits), clearing it on owner change; it SHALL increment only while the other req is high and saturate at MAX_BURST.
REQ-026 SHALL keep gnt one-hot or zero at all times; it SHALL never assert both.
REQ-027 SHALL sample requester changes of addr, we or wdata only in ACC; changes during RESP SHALL apply to the next beat.
REQ-028 SHALL make a req deassert during ACC have no effect: the beat still completes and done still pulses.

Reset
REQ-029 SHALL, on reset, immediately set state=IDLE, both gnt=0, both done=0, both rdata=0, Mem_CS=1, Mem_WR=0, Mem_Address=0, Mem_Data=0, burst_cnt=0 and last_owner=LDR.
REQ-030 SHALL, on reset asserted during ACC, release the strobe asynchronously; it SHALL produce no done pulse and SHALL NOT replay the beat after reset.

Configuration
REQ-031 SHALL, with macro MEM_ARB_RR_EN defined, resolve simultaneous requests in IDLE round-robin: the requester opposite last_owner wins, and last_owner updates on every grant.
REQ-032 SHALL, with MEM_ARB_RR_EN undefined, resolve simultaneous requests by fixed priority to the control unit; the MAX_BURST forced hand-over of REQ-023 SHALL still apply.

Verification
REQ-033 SHALL cover a single read: Mem_Q=8'h5A at addr 8'h10, cu_req for one beat -> Mem_CS low for 1 cycle with Mem_WR=0, then cu_done high for 1 cycle with cu_rdata=8'h5A.
REQ-034 SHALL cover a single write: ldr_req, ldr_we=1, addr 8'h20, data 8'hC3 -> Mem_CS=0, Mem_WR=1, Mem_Address=8'h20, Mem_Data=8'hC3 for 1 cycle, then ldr_done; cu_gnt stays 0.
REQ-035 SHALL cover a tie after reset: both req rise together -> cu granted first; with MEM_ARB_RR_EN, the next tie goes to ldr; without it, cu wins again.
REQ-036 SHALL cover starvation limit: MAX_BURST=4, cu_req held continuously while ldr_req is high -> exactly 4 cu_done pulses, then ldr_gnt, with ldr completing its beat before cu regains the port.
REQ-037 SHALL cover reset mid-beat: reset asserted during ACC of a cu write -> Mem_CS=1 the same cycle, no cu_done, all outputs at reset values; after release with req low, the block stays in IDLE.
